// File: rtl/axis_frame_master.sv
// AXI4-Stream frame master: buffers multi-channel sample vectors and serialises them
// channel by channel into fixed-length frames with TLAST/TUSER/TDEST framing.
module axis_frame_master #(
    parameter int DATA_W        = 32,
    parameter int NUM_CH        = 4,
    parameter int FRAME_SAMPLES = 16,
    parameter int FIFO_DEPTH    = 8,
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int AW    = $clog2(FIFO_DEPTH),
    localparam int LVL_W = AW + 1
) (
    input  logic                     clk,
    input  logic                     reset_b,
    input  logic [NUM_CH*DATA_W-1:0] i_s_data,
    input  logic                     i_s_valid,
    input  logic                     i_frame_req,
    input  logic                     i_ovf_clr,
    output logic [DATA_W-1:0]        o_m_tdata,
    output logic                     o_m_tvalid,
    input  logic                     i_m_tready,
    output logic                     o_m_tlast,
    output logic                     o_m_tuser,
    output logic [CH_W-1:0]          o_m_tdest,
    output logic                     o_busy,
    output logic                     o_frame_done,
    output logic                     o_ovf_flag,
    output logic [LVL_W-1:0]         o_fifo_level
);
    localparam int SMP_W = (FRAME_SAMPLES > 1) ? $clog2(FRAME_SAMPLES) : 1;

    typedef enum logic [1:0] {S_IDLE, S_SEND, S_DONE} state_t;

    state_t                         r_state;
    logic [NUM_CH-1:0][DATA_W-1:0]  r_mem [FIFO_DEPTH];
    logic [AW-1:0]                  r_wr_ptr, r_rd_ptr;
    logic [LVL_W-1:0]               r_level;
    logic [3:0]                     r_req_cnt;
    logic [CH_W-1:0]                r_ch_cnt;
    logic [SMP_W-1:0]               r_smp_cnt;
    logic                           r_ovf;

    logic w_empty, w_full, w_tvalid, w_accept, w_ch_last, w_smp_last;
    logic w_pop, w_push, w_drop, w_start;

    assign w_empty    = (r_level == '0);
    assign w_full     = (r_level == LVL_W'(FIFO_DEPTH));
    assign w_tvalid   = (r_state == S_SEND) && !w_empty;
    assign w_accept   = w_tvalid && i_m_tready;
    assign w_ch_last  = (r_ch_cnt == CH_W'(NUM_CH - 1));
    assign w_smp_last = (r_smp_cnt == SMP_W'(FRAME_SAMPLES - 1));
    assign w_pop      = w_accept && w_ch_last;
    // A full FIFO still accepts a write in the cycle its head vector retires.
    assign w_push     = i_s_valid && (!w_full || w_pop);
    assign w_drop     = i_s_valid && !w_push;
    assign w_start    = (r_state == S_IDLE) && (r_req_cnt != 4'd0);

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_s_data;
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            r_state   <= S_IDLE;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_level   <= '0;
            r_req_cnt <= 4'd0;
            r_ch_cnt  <= '0;
            r_smp_cnt <= '0;
            r_ovf     <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LVL_W'(1);
                2'b01:   r_level <= r_level - LVL_W'(1);
                default: r_level <= r_level;
            endcase

            // Clear first so a drop in the same cycle keeps the flag set.
            if (i_ovf_clr) r_ovf <= 1'b0;
            if (w_drop)    r_ovf <= 1'b1;

            if (i_frame_req && !w_start && r_req_cnt != 4'hF)
                r_req_cnt <= r_req_cnt + 4'd1;
            else if (w_start && !i_frame_req)
                r_req_cnt <= r_req_cnt - 4'd1;

            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_state   <= S_SEND;
                        r_ch_cnt  <= '0;
                        r_smp_cnt <= '0;
                    end
                end
                S_SEND: begin
                    // An empty FIFO simply holds the counters until data returns.
                    if (w_accept) begin
                        if (w_ch_last) begin
                            r_ch_cnt <= '0;
                            if (w_smp_last) r_state   <= S_DONE;
                            else            r_smp_cnt <= r_smp_cnt + SMP_W'(1);
                        end else begin
                            r_ch_cnt <= r_ch_cnt + CH_W'(1);
                        end
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_m_tvalid   = w_tvalid;
    assign o_m_tdata    = w_tvalid ? r_mem[r_rd_ptr][r_ch_cnt] : '0;
    assign o_m_tdest    = w_tvalid ? r_ch_cnt : '0;
    assign o_m_tuser    = w_tvalid && (r_ch_cnt == '0) && (r_smp_cnt == '0);
    assign o_m_tlast    = w_tvalid && w_ch_last && w_smp_last;
    assign o_busy       = (r_state != S_IDLE);
    assign o_frame_done = (r_state == S_DONE);
    assign o_ovf_flag   = r_ovf;
    assign o_fifo_level = r_level;
endmodule

// File: tb/tb_axis_frame_master.sv
// Directed bench for axis_frame_master: 4 channels, 2-sample frames (8 beats), 8-deep FIFO.
module tb_axis_frame_master;
    localparam int DW = 32, NC = 4, FS = 2, FD = 8, BEATS = NC * FS;

    logic              clk = 1'b0;
    logic              reset_b = 1'b0;
    logic [NC*DW-1:0]  i_s_data = '0;
    logic              i_s_valid = 1'b0, i_frame_req = 1'b0, i_ovf_clr = 1'b0, i_m_tready = 1'b1;
    logic [DW-1:0]     o_m_tdata;
    logic              o_m_tvalid, o_m_tlast, o_m_tuser, o_busy, o_frame_done, o_ovf_flag;
    logic [1:0]        o_m_tdest;
    logic [3:0]        o_fifo_level;

    int errors = 0;
    int checks = 0;

    axis_frame_master #(.DATA_W(DW), .NUM_CH(NC), .FRAME_SAMPLES(FS), .FIFO_DEPTH(FD)) dut (
        .clk(clk), .reset_b(reset_b), .i_s_data(i_s_data), .i_s_valid(i_s_valid),
        .i_frame_req(i_frame_req), .i_ovf_clr(i_ovf_clr), .o_m_tdata(o_m_tdata),
        .o_m_tvalid(o_m_tvalid), .i_m_tready(i_m_tready), .o_m_tlast(o_m_tlast),
        .o_m_tuser(o_m_tuser), .o_m_tdest(o_m_tdest), .o_busy(o_busy),
        .o_frame_done(o_frame_done), .o_ovf_flag(o_ovf_flag), .o_fifo_level(o_fifo_level));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Vector k carries channel values 4k+0 .. 4k+3.
    function automatic logic [NC*DW-1:0] vec(input int k);
        logic [NC*DW-1:0] v;
        for (int i = 0; i < NC; i++) v[i*DW +: DW] = DW'(NC * k + i);
        return v;
    endfunction

    task automatic push(input int k);
        i_s_data  = vec(k);
        i_s_valid = 1'b1;
        tick();
        i_s_valid = 1'b0;
    endtask

    task automatic req();
        i_frame_req = 1'b1;
        tick();
        i_frame_req = 1'b0;
    endtask

    // Collects frame beats first..last; beat b must carry base+b. Checks every valid
    // cycle, so a stalled beat that changes is caught. lat>=0 checks the first-valid cycle.
    task automatic frame(input int base, input int first, input int last, input int mode,
                         input int req_beat, input int lat);
        int b = first;
        int cyc = 0;
        int first_v = -1;
        bit rq = 1'b0;
        while (b <= last && cyc < 300) begin
            if (mode == 0)    i_m_tready = 1'b1;
            else if (cyc < 8) i_m_tready = (cyc % 2 == 0);
            else              i_m_tready = 1'($urandom_range(0, 1));
            i_frame_req = (b == req_beat) && !rq;
            if (i_frame_req) rq = 1'b1;
            #1;
            if (o_m_tvalid) begin
                if (first_v < 0) first_v = cyc;
                chk($sformatf("tdata b%0d", b), 64'(o_m_tdata), 64'(base + b));
                chk($sformatf("tdest b%0d", b), 64'(o_m_tdest), 64'(b % NC));
                chk($sformatf("tuser b%0d", b), 64'(o_m_tuser), 64'(b == 0));
                chk($sformatf("tlast b%0d", b), 64'(o_m_tlast), 64'(b == BEATS - 1));
                if (i_m_tready) b++;
            end
            tick();
            i_frame_req = 1'b0;
            cyc++;
        end
        i_m_tready = 1'b1;
        chk("beat count/timeout", 64'(b), 64'(last + 1));
        if (lat >= 0) chk("first beat latency", 64'(first_v), 64'(lat));
        if (last == BEATS - 1) begin
            chk("frame_done pulse", 64'(o_frame_done), 64'd1);
            chk("tvalid in DONE", 64'(o_m_tvalid), 64'd0);
            tick();
            chk("frame_done cleared", 64'(o_frame_done), 64'd0);
            chk("busy after DONE", 64'(o_busy), 64'd0);
        end
    endtask

    initial begin
        // Reset state
        #11;
        chk("rst tvalid", 64'(o_m_tvalid), 64'd0);
        chk("rst tdata", 64'(o_m_tdata), 64'd0);
        chk("rst tlast", 64'(o_m_tlast), 64'd0);
        chk("rst tuser", 64'(o_m_tuser), 64'd0);
        chk("rst busy", 64'(o_busy), 64'd0);
        chk("rst done", 64'(o_frame_done), 64'd0);
        chk("rst ovf", 64'(o_ovf_flag), 64'd0);
        chk("rst level", 64'(o_fifo_level), 64'd0);
        #1 reset_b = 1'b1;
        tick();

        // Basic frame, tready held high
        push(0);
        push(1);
        chk("t1 level", 64'(o_fifo_level), 64'd2);
        req();
        frame(0, 0, 7, 0, -1, 1);
        chk("t1 level drained", 64'(o_fifo_level), 64'd0);

        // Same frame shape under backpressure
        push(10);
        push(11);
        req();
        frame(40, 0, 7, 1, -1, 1);

        // Underrun mid-frame, resume on new data
        push(20);
        req();
        frame(80, 0, 3, 0, -1, 1);
        chk("t4 underrun tvalid", 64'(o_m_tvalid), 64'd0);
        chk("t4 underrun busy", 64'(o_busy), 64'd1);
        tick();
        chk("t4 still stalled", 64'(o_m_tvalid), 64'd0);
        chk("t4 still busy", 64'(o_busy), 64'd1);
        push(21);
        frame(80, 4, 7, 0, -1, 0);

        // Fill FIFO, overflow and sticky-flag clearing
        for (int k = 0; k < FD; k++) push(k);
        chk("t3 level full", 64'(o_fifo_level), 64'd8);
        chk("t3 no ovf yet", 64'(o_ovf_flag), 64'd0);
        push(8);
        chk("t3 ovf set", 64'(o_ovf_flag), 64'd1);
        chk("t3 level held", 64'(o_fifo_level), 64'd8);
        i_ovf_clr = 1'b1;
        tick();
        chk("t3 ovf cleared", 64'(o_ovf_flag), 64'd0);
        i_s_data  = vec(9);
        i_s_valid = 1'b1;
        tick();
        i_s_valid = 1'b0;
        chk("t3 clr vs drop", 64'(o_ovf_flag), 64'd1);
        tick();
        i_ovf_clr = 1'b0;
        chk("t3 ovf cleared again", 64'(o_ovf_flag), 64'd0);

        // Queued requests, one arriving mid-frame; drains the full FIFO
        i_frame_req = 1'b1;
        tick();
        tick();
        i_frame_req = 1'b0;
        frame(0, 0, 7, 0, 3, 0);
        frame(8, 0, 7, 0, -1, 1);
        frame(16, 0, 7, 0, -1, 1);
        chk("t5 level left", 64'(o_fifo_level), 64'd2);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t5 req drained idle", 64'(o_busy), 64'd0);
        end
        req();
        frame(24, 0, 7, 0, -1, 1);
        chk("t5 dropped vector absent", 64'(o_fifo_level), 64'd0);

        // Reset in the middle of a frame
        push(30);
        push(31);
        req();
        frame(120, 0, 2, 0, -1, 1);
        chk("t6 beat3 valid", 64'(o_m_tvalid), 64'd1);
        reset_b = 1'b0;
        #1;
        chk("t6 abort tvalid", 64'(o_m_tvalid), 64'd0);
        chk("t6 abort tdata", 64'(o_m_tdata), 64'd0);
        chk("t6 abort tlast", 64'(o_m_tlast), 64'd0);
        chk("t6 abort tdest", 64'(o_m_tdest), 64'd0);
        chk("t6 abort busy", 64'(o_busy), 64'd0);
        chk("t6 abort level", 64'(o_fifo_level), 64'd0);
        #3 reset_b = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t6 idle busy", 64'(o_busy), 64'd0);
            chk("t6 idle tvalid", 64'(o_m_tvalid), 64'd0);
        end
        chk("t6 idle level", 64'(o_fifo_level), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
